// File: rtl/usb_rx_phy.sv
// rtl/usb_rx_phy.sv - full-speed USB receive front end: sync, bit recovery, NRZI decode, destuff, bytes
module usb_rx_phy #(
  parameter int CLK_PER_BIT    = 4,
  parameter int RESET_CYCLES   = 120,
  parameter int MIN_SYNC_ZEROS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dp,
  input  logic       dm,
  input  logic       tx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_error,
  output logic       usb_reset
);
  localparam int PW = $clog2(CLK_PER_BIT);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam logic [PW-1:0] HALF      = PW'(CLK_PER_BIT / 2);
  localparam logic [RW-1:0] RST_MAX   = RW'(RESET_CYCLES);
  localparam logic [3:0]    MIN_ZEROS = 4'(MIN_SYNC_ZEROS);

  typedef enum logic [1:0] {LS_SE0 = 2'b00, LS_K = 2'b01, LS_J = 2'b10, LS_SE1 = 2'b11} line_t;
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ERROR} state_t;

  logic [1:0]    dp_sync, dm_sync;
  line_t         line, line_prev;
  logic [PW-1:0] phase, phase_cur;
  logic [RW-1:0] se0_cnt;
  logic          jk_edge, sample, is_jk, level, bit_val, force_idle;
  state_t        state, state_nxt;
  logic          prev_level, prev_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [2:0]    ones, ones_nxt, bit_cnt, bit_cnt_nxt;
  logic [7:0]    shreg, shreg_nxt, data_nxt;
  logic          se0_seen, se0_seen_nxt, valid_nxt, error_nxt;

  assign line      = line_t'({dp_sync[1], dm_sync[1]});
  assign jk_edge   = (line == LS_J && line_prev == LS_K) || (line == LS_K && line_prev == LS_J);
  // The edge cycle itself counts as phase 0, so the sample lands mid-bit.
  assign phase_cur = jk_edge ? '0 : phase;
  assign sample    = (phase_cur == HALF);
  assign is_jk     = (line == LS_J) || (line == LS_K);
  assign level     = (line == LS_J);
  assign bit_val   = (level == prev_level);
  assign usb_reset = (se0_cnt == RST_MAX);
  assign force_idle = tx_active || usb_reset;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dp_sync   <= 2'b11;
      dm_sync   <= 2'b00;
      line_prev <= LS_J;
      phase     <= '0;
      se0_cnt   <= '0;
    end else begin
      dp_sync   <= {dp_sync[0], dp};
      dm_sync   <= {dm_sync[0], dm};
      line_prev <= line;
      phase     <= phase_cur + 1'b1;
      if (line != LS_SE0)
        se0_cnt <= '0;
      else if (se0_cnt != RST_MAX)
        se0_cnt <= se0_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      prev_level <= 1'b1;
      cnt        <= '0;
      ones       <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      se0_seen   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_error   <= 1'b0;
      rx_active  <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev_level <= prev_nxt;
      cnt        <= cnt_nxt;
      ones       <= ones_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      se0_seen   <= se0_seen_nxt;
      rx_data    <= data_nxt;
      rx_valid   <= valid_nxt;
      rx_error   <= error_nxt;
      rx_active  <= (state_nxt == S_DATA) || (state_nxt == S_EOP) || (state_nxt == S_ERROR);
    end
  end

  always_comb begin
    state_nxt    = state;
    prev_nxt     = prev_level;
    cnt_nxt      = cnt;
    ones_nxt     = ones;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    se0_seen_nxt = se0_seen;
    data_nxt     = rx_data;
    valid_nxt    = 1'b0;
    error_nxt    = 1'b0;
    if (sample && is_jk)
      prev_nxt = level;
    case (state)
      S_IDLE: begin
        prev_nxt = 1'b1;
        cnt_nxt  = '0;
        if (sample && line == LS_K) begin
          state_nxt = S_SYNC;
          prev_nxt  = 1'b0;
          cnt_nxt   = 4'd1;
        end
      end
      S_SYNC: begin
        if (sample) begin
          if (line == LS_SE0) begin
            state_nxt = S_IDLE;
          end else if (line == LS_SE1) begin
            state_nxt = S_IDLE;
            error_nxt = 1'b1;
          end else if (!bit_val) begin
            if (cnt != 4'hF)
              cnt_nxt = cnt + 1'b1;
          end else if (cnt >= MIN_ZEROS) begin
            state_nxt   = S_DATA;
            ones_nxt    = '0;
            bit_cnt_nxt = '0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          if (line == LS_SE0) begin
            state_nxt = S_EOP;
            cnt_nxt   = '0;
            error_nxt = (bit_cnt != 3'd0);
          end else if (line == LS_SE1) begin
            state_nxt    = S_ERROR;
            error_nxt    = 1'b1;
            cnt_nxt      = '0;
            se0_seen_nxt = 1'b0;
          end else if (ones == 3'd6) begin
            if (!bit_val) begin
              ones_nxt = '0;
            end else begin
              state_nxt    = S_ERROR;
              error_nxt    = 1'b1;
              cnt_nxt      = '0;
              se0_seen_nxt = 1'b0;
            end
          end else begin
            ones_nxt    = bit_val ? ones + 1'b1 : 3'd0;
            shreg_nxt   = {bit_val, shreg[7:1]};
            bit_cnt_nxt = bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              data_nxt  = {bit_val, shreg[7:1]};
              valid_nxt = 1'b1;
            end
          end
        end
      end
      S_EOP: begin
        if (sample) begin
          if (line == LS_J) begin
            state_nxt = S_IDLE;
          end else if (cnt == 4'd2) begin
            state_nxt    = S_ERROR;
            error_nxt    = 1'b1;
            cnt_nxt      = '0;
            se0_seen_nxt = (line == LS_SE0);
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      S_ERROR: begin
        if (sample) begin
          case (line)
            LS_SE0: begin
              se0_seen_nxt = 1'b1;
              cnt_nxt      = '0;
            end
            LS_J: begin
              if (se0_seen || cnt == 4'd7)
                state_nxt = S_IDLE;
              else
                cnt_nxt = cnt + 1'b1;
            end
            default: cnt_nxt = '0;
          endcase
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (force_idle) begin
      state_nxt = S_IDLE;
      prev_nxt  = 1'b1;
      valid_nxt = 1'b0;
      error_nxt = 1'b0;
      data_nxt  = rx_data;
    end
  end
endmodule

// File: tb/tb_usb_rx_phy.sv
// tb/tb_usb_rx_phy.sv - self-checking bench for usb_rx_phy against a packet-level line model
module tb_usb_rx_phy;
  localparam int CPB = 4;
  localparam int RST = 120;
  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;

  logic       clk = 1'b0;
  logic       rst_n, dp, dm, tx_active;
  logic [7:0] rx_data;
  logic       rx_valid, rx_active, rx_error, usb_reset;

  int errors = 0;
  int checks = 0;

  usb_rx_phy #(.CLK_PER_BIT(CPB), .RESET_CYCLES(RST), .MIN_SYNC_ZEROS(3)) dut (
    .clk(clk), .rst_n(rst_n), .dp(dp), .dm(dm), .tx_active(tx_active),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_active(rx_active),
    .rx_error(rx_error), .usb_reset(usb_reset)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int err_total = 0, both_total = 0, active_total = 0;
  int fall_cyc = -1, last_valid_cyc = -1, last_err_cyc = -1;
  logic active_d = 1'b0;
  logic [7:0] got[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      got.push_back(rx_data);
      last_valid_cyc <= cyc;
    end
    if (rx_error === 1'b1) begin
      err_total    <= err_total + 1;
      last_err_cyc <= cyc;
    end
    if (rx_valid === 1'b1 && rx_error === 1'b1) both_total <= both_total + 1;
    if (rx_active === 1'b1) active_total <= active_total + 1;
    if (active_d && rx_active === 1'b0) fall_cyc <= cyc;
    active_d <= (rx_active === 1'b1);
  end

  // Line model: SYNC, LSB-first data with a 0 inserted after every six 1s, NRZI from J.
  bit         bits_q[$];
  logic [1:0] syms[$];
  logic [7:0] exp_q[$];
  int         ones_run, eop_j_idx, j_drive_cyc;

  function automatic void start_pkt();
    bits_q.delete();
    exp_q.delete();
    for (int i = 0; i < 7; i++) bits_q.push_back(1'b0);
    bits_q.push_back(1'b1);
    ones_run = 0;
  endfunction

  function automatic void add_bits(input logic [7:0] b, input int n, input bit stuff);
    for (int i = 0; i < n; i++) begin
      bits_q.push_back(b[i]);
      if (stuff) begin
        ones_run = b[i] ? ones_run + 1 : 0;
        if (ones_run == 6) begin
          bits_q.push_back(1'b0);
          ones_run = 0;
        end
      end
    end
    if (n == 8 && stuff) exp_q.push_back(b);
  endfunction

  function automatic void finish_pkt(input bit eop);
    logic lvl;
    lvl = 1'b1;
    syms.delete();
    foreach (bits_q[i]) begin
      if (!bits_q[i]) lvl = ~lvl;
      syms.push_back({lvl, ~lvl});
    end
    eop_j_idx = -1;
    if (eop) begin
      syms.push_back(SE0);
      syms.push_back(SE0);
      eop_j_idx = syms.size();
      repeat (6) syms.push_back(J);
    end
  endfunction

  function automatic logic [15:0] crc16(input logic [7:0] d);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return ~c;
  endfunction

  // Symbol boundaries sit on absolute multiples of CPB plus 0/1 cycle jitter, so bits last 3..5 cycles.
  task automatic send(input bit jit);
    int b0, b1;
    b0 = 0;
    for (int i = 0; i < syms.size(); i++) begin
      b1 = CPB * (i + 1) + ((jit && i + 1 < syms.size()) ? int'($urandom_range(1, 0)) : 0);
      {dp, dm} = syms[i];
      if (i == eop_j_idx) j_drive_cyc = cyc;
      repeat (b1 - b0) begin
        @(posedge clk);
        #1;
      end
      b0 = b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dp = 1'b1; dm = 1'b0; tx_active = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL reset_rx_active: got %b want 0", rx_active); end
    checks++; if (rx_error !== 1'b0) begin errors++; $display("FAIL reset_rx_error: got %b want 0", rx_error); end
    checks++; if (usb_reset !== 1'b0) begin errors++; $display("FAIL reset_usb_reset: got %b want 0", usb_reset); end
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic test_packet();
    int g0, e0;
    logic [15:0] crc;
    g0 = got.size(); e0 = err_total;
    crc = crc16(8'h00);
    start_pkt();
    add_bits(8'hC3, 8, 1); add_bits(8'h00, 8, 1);
    add_bits(crc[7:0], 8, 1); add_bits(crc[15:8], 8, 1);
    finish_pkt(1);
    send(0);
    checks++; if (got.size() - g0 != exp_q.size()) begin errors++; $display("FAIL pkt_count: got %0d want %0d", got.size() - g0, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
      checks++; if (got[g0 + i] !== exp_q[i]) begin errors++; $display("FAIL pkt_byte%0d: got %h want %h", i, got[g0 + i], exp_q[i]); end
    end
    checks++; if (err_total != e0) begin errors++; $display("FAIL pkt_errors: got %0d want 0", err_total - e0); end
    // J seen after 2 sync stages, sampled at half a bit, rx_active drops on the next edge.
    checks++; if (fall_cyc - j_drive_cyc != 2 + CPB / 2 + 1) begin errors++; $display("FAIL pkt_active_fall: got %0d want %0d", fall_cyc - j_drive_cyc, 2 + CPB / 2 + 1); end
    checks++; if (!(last_valid_cyc < fall_cyc)) begin errors++; $display("FAIL pkt_order: valid %0d fall %0d want valid before fall", last_valid_cyc, fall_cyc); end
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL pkt_idle: got %b want 0", rx_active); end
  endtask

  task automatic test_stuffing();
    int g0, e0;
    logic [7:0] r;
    g0 = got.size(); e0 = err_total;
    r = 8'($urandom);
    start_pkt();
    add_bits(8'hFF, 8, 1); add_bits(8'h7E, 8, 1); add_bits(r, 8, 1);
    finish_pkt(1);
    send(0);
    checks++; if (got.size() - g0 != 3) begin errors++; $display("FAIL stuff_count: got %0d want 3", got.size() - g0); end
    for (int i = 0; i < 3 && g0 + i < got.size(); i++) begin
      checks++; if (got[g0 + i] !== exp_q[i]) begin errors++; $display("FAIL stuff_byte%0d: got %h want %h", i, got[g0 + i], exp_q[i]); end
    end
    checks++; if (err_total != e0) begin errors++; $display("FAIL stuff_errors: got %0d want 0", err_total - e0); end
    g0 = got.size(); e0 = err_total;
    start_pkt();
    add_bits(8'h7F, 7, 0);
    finish_pkt(1);
    send(0);
    checks++; if (err_total - e0 != 1) begin errors++; $display("FAIL seven_ones_error: got %0d want 1", err_total - e0); end
    checks++; if (got.size() != g0) begin errors++; $display("FAIL seven_ones_valid: got %0d want 0", got.size() - g0); end
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL seven_ones_idle: got %b want 0", rx_active); end
  endtask

  task automatic test_usb_reset();
    int ns[3];
    int hi, first, exp_hi;
    ns[0] = RST - 1; ns[1] = RST; ns[2] = RST + 1 + int'($urandom_range(40, 0));
    foreach (ns[t]) begin
      hi = 0; first = -1;
      dp = 1'b0; dm = 1'b0;
      for (int k = 1; k <= ns[t] + 8; k++) begin
        @(posedge clk);
        #1;
        if (k == ns[t]) begin dp = 1'b1; dm = 1'b0; end
        if (usb_reset === 1'b1) begin
          hi++;
          if (first < 0) first = k;
        end
      end
      exp_hi = (ns[t] >= RST) ? ns[t] - RST + 1 : 0;
      checks++; if (hi != exp_hi) begin errors++; $display("FAIL usb_reset_len_%0d: got %0d want %0d", ns[t], hi, exp_hi); end
      if (exp_hi > 0) begin
        checks++; if (first != RST + 2) begin errors++; $display("FAIL usb_reset_rise_%0d: got %0d want %0d", ns[t], first, RST + 2); end
      end
    end
  endtask

  task automatic test_sync_and_eop();
    int a0, g0, e0, b0;
    logic [7:0] b, nib;
    a0 = active_total; e0 = err_total;
    syms.delete();
    syms = '{K, J, J, J, J, SE0, SE0, J, J, J, J, J};
    eop_j_idx = -1;
    send(0);
    checks++; if (active_total != a0) begin errors++; $display("FAIL short_sync_active: got %0d cycles want 0", active_total - a0); end
    checks++; if (err_total != e0) begin errors++; $display("FAIL short_sync_error: got %0d want 0", err_total - e0); end
    g0 = got.size(); e0 = err_total; b0 = both_total;
    b = 8'($urandom); nib = 8'($urandom);
    start_pkt();
    add_bits(b, 8, 1); add_bits(nib, 4, 1);
    finish_pkt(1);
    send(0);
    checks++; if (got.size() - g0 != 1) begin errors++; $display("FAIL misalign_count: got %0d want 1", got.size() - g0); end
    if (got.size() > g0) begin
      checks++; if (got[g0] !== b) begin errors++; $display("FAIL misalign_byte: got %h want %h", got[g0], b); end
    end
    checks++; if (err_total - e0 != 1) begin errors++; $display("FAIL misalign_error: got %0d want 1", err_total - e0); end
    checks++; if (!(last_err_cyc > last_valid_cyc)) begin errors++; $display("FAIL misalign_order: err %0d valid %0d want err after valid", last_err_cyc, last_valid_cyc); end
    checks++; if (both_total != b0) begin errors++; $display("FAIL misalign_overlap: got %0d want 0", both_total - b0); end
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL misalign_idle: got %b want 0", rx_active); end
  endtask

  task automatic test_jitter();
    int g0, e0;
    for (int p = 0; p < 3; p++) begin
      g0 = got.size(); e0 = err_total;
      start_pkt();
      for (int i = 0; i < 6; i++) add_bits(8'($urandom), 8, 1);
      finish_pkt(1);
      send(1);
      checks++; if (got.size() - g0 != 6) begin errors++; $display("FAIL jitter%0d_count: got %0d want 6", p, got.size() - g0); end
      for (int i = 0; i < 6 && g0 + i < got.size(); i++) begin
        checks++; if (got[g0 + i] !== exp_q[i]) begin errors++; $display("FAIL jitter%0d_byte%0d: got %h want %h", p, i, got[g0 + i], exp_q[i]); end
      end
      checks++; if (err_total != e0) begin errors++; $display("FAIL jitter%0d_errors: got %0d want 0", p, err_total - e0); end
    end
  endtask

  task automatic test_tx_active();
    int g0, e0, a0;
    g0 = got.size(); e0 = err_total; a0 = active_total;
    tx_active = 1'b1;
    start_pkt();
    for (int i = 0; i < 3; i++) add_bits(8'($urandom), 8, 1);
    finish_pkt(1);
    send(0);
    tx_active = 1'b0;
    checks++; if (got.size() != g0) begin errors++; $display("FAIL tx_valid: got %0d want 0", got.size() - g0); end
    checks++; if (err_total != e0) begin errors++; $display("FAIL tx_error: got %0d want 0", err_total - e0); end
    checks++; if (active_total != a0) begin errors++; $display("FAIL tx_active_out: got %0d cycles want 0", active_total - a0); end
    g0 = got.size();
    start_pkt();
    for (int i = 0; i < 3; i++) add_bits(8'($urandom), 8, 1);
    finish_pkt(1);
    send(0);
    checks++; if (got.size() - g0 != 3) begin errors++; $display("FAIL tx_release_count: got %0d want 3", got.size() - g0); end
    for (int i = 0; i < 3 && g0 + i < got.size(); i++) begin
      checks++; if (got[g0 + i] !== exp_q[i]) begin errors++; $display("FAIL tx_release_byte%0d: got %h want %h", i, got[g0 + i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] b;
    b = 8'($urandom_range(255, 1));
    start_pkt();
    add_bits(b, 8, 1); add_bits(8'($urandom), 4, 1);
    finish_pkt(0);
    send(0);
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (rx_active !== 1'b1) begin errors++; $display("FAIL mid_active: got %b want 1", rx_active); end
    checks++; if (rx_data !== b) begin errors++; $display("FAIL mid_data: got %h want %h", rx_data, b); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if ({rx_data, rx_valid, rx_active, rx_error, usb_reset} !== 12'h000) begin
      errors++; $display("FAIL mid_reset_outputs: got data=%h v=%b a=%b e=%b r=%b want all 0", rx_data, rx_valid, rx_active, rx_error, usb_reset);
    end
    dp = 1'b1; dm = 1'b0; rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_stuffing();
    test_usb_reset();
    test_sync_and_eop();
    test_jitter();
    test_tx_active();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
